result_bcd_decoder: RTL and testbench
=====================================

RESULT_BCD_DECODER -- requirements
Module: result_bcd_decoder

Interface
REQ-001 Parameters: none; data width fixed at 8-bit two's-complement input, three 4-bit BCD digits out.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 start  input  1  one-cycle request to convert `result`; sampled on rising edge.
REQ-005 result  input  8  signed two's-complement value from the adder stage, range -128..127.
REQ-006 busy  output  1  high while a conversion is in progress.
REQ-007 done  output  1  level; high from conversion end until the next start or reset.
REQ-008 sign  output  1  1 = negative result.
REQ-009 bcd_hundreds  output  4  magnitude hundreds digit, 0..1.
REQ-010 bcd_tens  output  4  magnitude tens digit, 0..9.
REQ-011 bcd_ones  output  4  magnitude ones digit, 0..9.

Function
REQ-012 The FSM SHALL have states IDLE, CONV and DONE, plus a 4-bit shift counter and a 20-bit shift register (12-bit BCD field and 8-bit binary field).
REQ-013 At the edge where start=1 (edge N), in any state, the block SHALL do all of the following:
- capture sign=result[7];
- load the binary field with |result|: ~result+1 when negative, 8-bit unsigned, so -128 gives 128;
- clear the BCD field, counter, all digit outputs and done;
- enter CONV.
REQ-014 In CONV, each edge SHALL perform one double-dabble step: add 3 to every BCD nibble >=5, then shift the 20-bit register left by one, then increment the counter.
REQ-015 At edge N+8, the eighth step SHALL complete, the digit outputs SHALL load the post-shift BCD field, and the FSM SHALL enter DONE; latency start->done = 8 cycles.
REQ-016 busy SHALL be high exactly in CONV (after edge N through edge N+8); done SHALL be high exactly in DONE; busy and done SHALL never both be high.
REQ-017 In DONE, outputs SHALL hold until the next start; with start=0, DONE and IDLE SHALL be stable.
REQ-018 start during CONV SHALL abort the current conversion and restart per REQ-013 with the new result; no done pulse from the aborted conversion.
REQ-019 result SHALL be sampled only at the start edge; changes on result during CONV SHALL not affect the output.
REQ-020 Zero SHALL produce sign=0 and digits 0,0,0; negative zero cannot occur.
REQ-021 No digit output SHALL ever hold a value >9; bcd_hundreds SHALL be <=1.

Reset
REQ-022 On rst assertion, asynchronously and in any state, the block SHALL enter IDLE and set counter, shift register, sign, all digits, busy and done to 0.
REQ-023 While rst is high, start SHALL be ignored; the first start after rst deasserts SHALL behave per REQ-013.
REQ-024 rst during CONV SHALL discard the conversion with no done assertion.

Verification
REQ-025 The bench SHALL cover these directed scenarios:
- result=0x05, start pulse -> busy for 8 cycles, then done=1, sign=0, digits 0/0/5.
- result=0xF9 (-7) -> sign=1, digits 0/0/7; result=0xFF (-1) -> sign=1, digits 0/0/1.
- result=0x7F -> sign=0, digits 1/2/7; result=0x80 -> sign=1, digits 1/2/8.
- start with 0x7F, second start with 0x0C three cycles later -> single done, 8 cycles after the second start; sign=0, digits 0/1/2.
- rst asserted asynchronously (between edges) at cycle 4 of a conversion -> all outputs 0 immediately and done never asserted; a following start with 0x2A -> digits 0/4/2.
- done held 20 cycles with start=0 and result toggling -> outputs unchanged.

Source files
------------

// File: rtl/result_bcd_decoder_if.sv
// Handshake and result bus between the adder stage and the BCD decoder.
// The slave side is the decoder; the master side supplies start/result and reads the digits.
interface result_bcd_decoder_if;
    logic       start;
    logic [7:0] result;
    logic       busy;
    logic       done;
    logic       sign;
    logic [3:0] bcd_hundreds;
    logic [3:0] bcd_tens;
    logic [3:0] bcd_ones;

    modport master (
        output start,
        output result,
        input  busy,
        input  done,
        input  sign,
        input  bcd_hundreds,
        input  bcd_tens,
        input  bcd_ones
    );

    modport slave (
        input  start,
        input  result,
        output busy,
        output done,
        output sign,
        output bcd_hundreds,
        output bcd_tens,
        output bcd_ones
    );
endinterface

// File: rtl/result_bcd_decoder.sv
// Converts an 8-bit signed result into sign + three BCD magnitude digits using
// an 8-step sequential double-dabble; a new start always restarts the conversion.
module result_bcd_decoder (
    input  logic                  clk,
    input  logic                  rst,
    result_bcd_decoder_if.slave   bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [3:0] LAST_STEP = 4'd7;

    state_t       state_q, state_d;
    logic [3:0]   cnt_q, cnt_d;
    logic [19:0]  sreg_q, sreg_d;
    logic         sign_q, sign_d;
    logic         busy_q, busy_d;
    logic         done_q, done_d;
    logic [3:0]   hund_q, hund_d;
    logic [3:0]   tens_q, tens_d;
    logic [3:0]   ones_q, ones_d;

    logic signed [7:0] result_s;
    logic [19:0]       step_s;

    // Magnitude as an unsigned 8-bit value so that -128 maps to 128.
    function automatic logic [7:0] abs_mag(input logic signed [7:0] v);
        logic [7:0] u;
        u = v;
        return u[7] ? (~u + 8'd1) : u;
    endfunction

    // One double-dabble step: correct every BCD nibble >= 5, then shift left.
    function automatic logic [19:0] dabble_step(input logic [19:0] s);
        logic [19:0] a;
        a = s;
        for (int i = 0; i < 3; i++) begin
            if (a[8 + 4*i +: 4] >= 4'd5) begin
                a[8 + 4*i +: 4] = a[8 + 4*i +: 4] + 4'd3;
            end
        end
        return {a[18:0], 1'b0};
    endfunction

    assign result_s = bus.result;
    assign step_s   = dabble_step(sreg_q);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sreg_d  = sreg_q;
        sign_d  = sign_q;
        busy_d  = busy_q;
        done_d  = done_q;
        hund_d  = hund_q;
        tens_d  = tens_q;
        ones_d  = ones_q;

        if (bus.start) begin
            state_d = CONV;
            cnt_d   = 4'd0;
            sreg_d  = {12'd0, abs_mag(result_s)};
            sign_d  = result_s[7];
            busy_d  = 1'b1;
            done_d  = 1'b0;
            hund_d  = 4'd0;
            tens_d  = 4'd0;
            ones_d  = 4'd0;
        end else begin
            case (state_q)
                CONV: begin
                    sreg_d = step_s;
                    cnt_d  = cnt_q + 4'd1;
                    // The eighth step publishes the freshly shifted BCD field.
                    if (cnt_q == LAST_STEP) begin
                        state_d = DONE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        hund_d  = step_s[19:16];
                        tens_d  = step_s[15:12];
                        ones_d  = step_s[11:8];
                    end
                end
                default: begin
                    state_d = state_q;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            sreg_q  <= 20'd0;
            sign_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            hund_q  <= 4'd0;
            tens_q  <= 4'd0;
            ones_q  <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sreg_q  <= sreg_d;
            sign_q  <= sign_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            hund_q  <= hund_d;
            tens_q  <= tens_d;
            ones_q  <= ones_d;
        end
    end

    assign bus.busy         = busy_q;
    assign bus.done         = done_q;
    assign bus.sign         = sign_q;
    assign bus.bcd_hundreds = hund_q;
    assign bus.bcd_tens     = tens_q;
    assign bus.bcd_ones     = ones_q;

endmodule

// File: tb/tb_result_bcd_decoder.sv
// Directed and randomized checks of result_bcd_decoder against an arithmetic
// reference (division/modulo of the magnitude), sampled 1 time unit after edges.
module tb_result_bcd_decoder;

    logic clk;
    logic rst;
    int   n_assert;
    int   n_fail;

    result_bcd_decoder_if bif ();

    result_bcd_decoder dut (
        .clk (clk),
        .rst (rst),
        .bus (bif.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {busy, done, sign, hundreds, tens, ones}
    function automatic logic [14:0] outs();
        return {bif.busy, bif.done, bif.sign, bif.bcd_hundreds, bif.bcd_tens, bif.bcd_ones};
    endfunction

    // Expected settled outputs after a finished conversion of r.
    function automatic logic [14:0] model(input logic [7:0] r);
        int v;
        int m;
        logic [3:0] h, t, o;
        v = int'($signed(r));
        m = (v < 0) ? -v : v;
        h = 4'(m / 100);
        t = 4'((m / 10) % 10);
        o = 4'(m % 10);
        return {1'b0, 1'b1, (v < 0), h, t, o};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Full conversion: check busy for 8 cycles with result scrambled, then the model.
    task automatic convert(input logic [7:0] r, input string tag);
        bif.result = r;
        bif.start  = 1'b1;
        tick();
        bif.start  = 1'b0;
        for (int i = 0; i < 7; i++) begin
            bif.result = 8'($urandom);
            chk({tag, "_busy"}, {30'd0, bif.busy, bif.done}, 32'b10);
            tick();
        end
        chk({tag, "_busy_last"}, {30'd0, bif.busy, bif.done}, 32'b10);
        tick();
        chk({tag, "_result"}, 32'(outs()), 32'(model(r)));
    endtask

    initial begin
        n_assert   = 0;
        n_fail     = 0;
        rst        = 1'b1;
        bif.start  = 1'b0;
        bif.result = 8'd0;
        tick();
        tick();
        chk("reset_state", 32'(outs()), 32'd0);
        #2 rst = 1'b0;
        tick();
        chk("idle_after_reset", 32'(outs()), 32'd0);

        convert(8'h05, "pos5");
        convert(8'hF9, "neg7");
        convert(8'hFF, "neg1");
        convert(8'h7F, "max");
        convert(8'h80, "min");
        convert(8'h00, "zero");

        // Abort: second start three cycles after the first.
        bif.result = 8'h7F;
        bif.start  = 1'b1;
        tick();
        bif.start  = 1'b0;
        tick();
        chk("abort_mid1", 32'(outs()), 32'h4000);
        tick();
        chk("abort_mid2", 32'(outs()), 32'h4000);
        convert(8'h0C, "abort_restart");

        // Asynchronous reset in the middle of a conversion.
        bif.result = 8'h63;
        bif.start  = 1'b1;
        tick();
        bif.start  = 1'b0;
        tick();
        tick();
        tick();
        #3 rst = 1'b1;
        #1;
        chk("async_rst_clear", 32'(outs()), 32'd0);
        bif.result = 8'h55;
        bif.start  = 1'b1;
        tick();
        chk("start_ignored_in_rst", 32'(outs()), 32'd0);
        bif.start = 1'b0;
        #2 rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("no_done_after_rst", 32'(outs()), 32'd0);
        end
        convert(8'h2A, "after_rst");

        // DONE holds with start low and result toggling.
        convert(8'h9C, "hold_setup");
        for (int i = 0; i < 20; i++) begin
            bif.result = 8'($urandom);
            tick();
            chk("done_hold", 32'(outs()), 32'(model(8'h9C)));
        end

        // Randomized conversions.
        for (int i = 0; i < 30; i++) begin
            convert(8'($urandom), "random");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
